// File: rtl/src_multicycle_cpu_if.sv
// rtl/src_multicycle_cpu_if.sv - memory bus between the multicycle CPU and its word memory
interface src_multicycle_cpu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/src_multicycle_cpu.sv
// rtl/src_multicycle_cpu.sv - multicycle CPU: FETCH/DECODE/EXEC/MEM/WB/HALT over a ready-handshaked memory
module src_multicycle_cpu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  src_multicycle_cpu_if.master  mem,
  input  logic [4:0]            reg_select,
  output logic [DATA_W-1:0]     reg_value,
  output logic                  halted,
  output logic                  illegal,
  output logic [31:0]           retired
);
  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LD   = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd3;
  localparam logic [4:0] OP_LA   = 5'd5;
  localparam logic [4:0] OP_BR   = 5'd8;
  localparam logic [4:0] OP_ADD  = 5'd12;
  localparam logic [4:0] OP_ADDI = 5'd13;
  localparam logic [4:0] OP_SUB  = 5'd14;
  localparam logic [4:0] OP_AND  = 5'd20;
  localparam logic [4:0] OP_OR   = 5'd22;
  localparam logic [4:0] OP_STOP = 5'd31;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, a_q, b_q, c_q, md_q;
  logic [31:0]       ir_q, retired_q;
  logic              illegal_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [4:0]        opcode, rb_f;
  logic [RI_W-1:0]   ra, rb, rc;
  logic [DATA_W-1:0] c2, base, alu_c;
  logic [2:0]        cond;
  logic              br_take, op_illegal;
  logic              rd_c, wr_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign opcode = ir_q[31:27];
  assign rb_f   = ir_q[21:17];
  assign ra     = ir_q[22 +: RI_W];
  assign rb     = ir_q[17 +: RI_W];
  assign rc     = ir_q[12 +: RI_W];
  assign c2     = {{(DATA_W-17){ir_q[16]}}, ir_q[16:0]};
  assign cond   = ir_q[2:0];

  always_comb begin
    base    = (rb_f == 5'd0) ? '0 : a_q;
    alu_c   = '0;
    br_take = 1'b0;
    case (opcode)
      OP_LD, OP_ST, OP_LA: alu_c = base + c2;
      OP_ADD:              alu_c = a_q + b_q;
      OP_ADDI:             alu_c = a_q + c2;
      OP_SUB:              alu_c = a_q - b_q;
      OP_AND:              alu_c = a_q & b_q;
      OP_OR:               alu_c = a_q | b_q;
      default:             alu_c = '0;
    endcase
    case (cond)
      3'd1:    br_take = 1'b1;
      3'd2:    br_take = (b_q == '0);
      3'd3:    br_take = (b_q != '0);
      3'd4:    br_take = ~b_q[DATA_W-1];
      3'd5:    br_take = b_q[DATA_W-1];
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_illegal = 1'b0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    case (state_q)
      FETCH: begin
        rd_c   = 1'b1;
        addr_c = pc_q[ADDR_W-1:0];
        if (mem.mem_ready) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (opcode)
          OP_LD, OP_ST:                                 state_d = MEM;
          OP_LA, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR: state_d = WB;
          OP_BR, OP_NOP:                                state_d = FETCH;
          OP_STOP:                                      state_d = HALT;
          default: begin
            state_d    = HALT;
            op_illegal = 1'b1;
          end
        endcase
      end
      MEM: begin
        addr_c = c_q[ADDR_W-1:0];
        if (opcode == OP_LD) begin
          rd_c = 1'b1;
        end else begin
          wr_c    = 1'b1;
          wdata_c = regs_q[ra];
        end
        if (mem.mem_ready) state_d = (opcode == OP_LD) ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // Reset wins immediately so an in-flight access is abandoned this cycle.
    if (reset) begin
      rd_c = 1'b0;
      wr_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      md_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: if (mem.mem_ready) begin
          ir_q <= mem.mem_rdata[31:0];
          pc_q <= pc_q + DATA_W'(1);
        end
        DECODE: begin
          a_q <= regs_q[rb];
          b_q <= regs_q[rc];
        end
        EXEC: begin
          c_q <= alu_c;
          if (opcode == OP_BR && br_take) pc_q <= a_q;
          if (opcode == OP_BR || opcode == OP_NOP) retired_q <= retired_q + 32'd1;
          if (op_illegal) illegal_q <= 1'b1;
        end
        MEM: if (mem.mem_ready) begin
          if (opcode == OP_LD) md_q <= mem.mem_rdata;
          else                 retired_q <= retired_q + 32'd1;
        end
        WB: begin
          regs_q[ra] <= (opcode == OP_LD) ? md_q : c_q;
          retired_q  <= retired_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_read  = rd_c;
  assign mem.mem_write = wr_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;
  assign reg_value     = regs_q[reg_select[RI_W-1:0]];
  assign halted        = (state_q == HALT);
  assign illegal       = illegal_q;
  assign retired       = retired_q;
endmodule

// File: doc/src_multicycle_cpu.md
SRC_MULTICYCLE_CPU -- requirements
Module: src_multicycle_cpu

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, datapath and register width (minimum 32).
REQ-002 SHALL provide parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL provide parameter NREGS, default 32, number of general registers (power of 2, at most 32).
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port mem_addr  output  ADDR_W  word address, equal to the low ADDR_W bits of the internal address.
REQ-007 SHALL provide ports mem_rdata  input  DATA_W and mem_wdata  output  DATA_W as the memory data paths.
REQ-008 SHALL provide ports mem_read  output  1 and mem_write  output  1 as request strobes, never both high.
REQ-009 SHALL provide port mem_ready  input  1  memory completion; may stay low for any number of cycles.
REQ-010 SHALL provide ports reg_select  input  5 and reg_value  output  DATA_W as a combinational debug read of R[reg_select mod NREGS].
REQ-011 SHALL provide ports halted  output  1, illegal  output  1 and retired  output  32  (retired-instruction count).

Function
REQ-012 SHALL decode the instruction as: opcode=ir[31:27], ra=ir[26:22], rb=ir[21:17], rc=ir[16:12], c2=ir[16:0] sign-extended to DATA_W, cond=ir[2:0].
REQ-013 SHALL implement the opcodes nop=0, ld=1, st=3, la=5, br=8, add=12, addi=13, sub=14, and=20, or=22 and stop=31; every other opcode is illegal.
REQ-014 SHALL compute the ld/st/la effective address as (rb==0 ? 0 : R[rb]) + c2, modulo 2^DATA_W.
REQ-015 SHALL compute add/sub/and/or as R[rb] op R[rc] and addi as R[rb]+c2, with wrap-around and no flags.
REQ-016 SHALL implement br as pc<=R[rb] when the condition on R[rc] holds: cond 0=never, 1=always, 2=R[rc]==0, 3=R[rc]!=0, 4=R[rc] non-negative, 5=R[rc] negative, 6/7=never.
REQ-017 SHALL use a state machine with states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-018 FETCH SHALL drive mem_read=1 and mem_addr=pc; on mem_ready=1 it SHALL set ir<=mem_rdata and pc<=pc+1, then go to DECODE.
REQ-019 DECODE SHALL latch the operands A and B from the register file, then go to EXEC.
REQ-020 EXEC SHALL latch result C and dispatch: ld/st go to MEM; la/ALU ops go to WB; br/nop go to FETCH; stop goes to HALT; an illegal opcode goes to HALT and sets illegal=1.
REQ-021 MEM SHALL drive mem_addr=C and hold its strobe until mem_ready=1: ld uses mem_read and captures mem_rdata into MD, then goes to WB; st uses mem_write with mem_wdata=R[ra], then goes to FETCH.
REQ-022 WB SHALL write R[ra] with MD for ld or C otherwise, then go to FETCH.
REQ-023 SHALL deassert each strobe in the cycle after mem_ready is sampled high; strobes and mem_addr SHALL be stable while waiting.
REQ-024 With mem_ready tied high, SHALL take 3 cycles for br/nop, 4 for ALU/la/st and 5 for ld, measured from FETCH entry to the next FETCH entry.
REQ-025 SHALL increment retired by 1 (wrapping at 2^32) on completion of each nop, ld, st, la, br or ALU instruction; stop and illegal opcodes are not counted.
REQ-026 SHALL wrap pc at 2^DATA_W.
REQ-027 In HALT, SHALL hold halted=1, drive no strobes and stay there until reset.
REQ-028 SHALL let a WB write to R[ra] be visible to the next instruction's DECODE, since no bypass is needed.

Reset
REQ-029 On reset=1 at a clock edge, SHALL set pc=0, ir=0, all R=0, state=FETCH, halted=0, illegal=0, retired=0 and drop mem_read/mem_write.
REQ-030 SHALL let reset override any state, including a pending memory wait, with no write completing that cycle.
REQ-031 After reset, mem_addr and mem_wdata SHALL be 0 until the first FETCH cycle.

Verification
REQ-032 Memory holds ld r1,5(r0) at 0 and 0x1234 at 5, ready high -> after 5 cycles R1=0x1234, pc=1, retired=1.
REQ-033 R2=7, R3=9: add r4,r2,r3, sub r5,r2,r3, stop -> R4=16, R5=0xFFFFFFFE, halted=1, retired=2.
REQ-034 st r2,8(r0) with R2=0xAA and mem_ready delayed 3 cycles -> mem_write held 4 cycles, addr=8, wdata=0xAA.
REQ-035 R6=0, R7=20: br r7,r6 with cond=2 -> next fetch at 20; with cond=3 -> next fetch at pc+1.
REQ-036 Opcode 30 fetched -> illegal=1, halted=1 and no further strobes.
REQ-037 reset asserted during an ld MEM wait -> next cycle strobes=0, pc=0, R unchanged from its reset value 0.
